// File: rtl/greedy_snake_pkg.sv
// Shared types and constants for the snake list reader: FSM states, DPB node layout, position helpers.
// Optional build macro used by the reader: GREEDY_SNAKE_SELF_HIT_EN.
package greedy_snake_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_COMMIT = 2'd2,
      S_FAIL   = 2'd3
   } state_t;

   localparam logic [10:0] NULL_ADDR      = 11'd0;
   localparam logic [10:0] POS_OFS        = 11'd0;
   localparam logic [10:0] NEXT_HI_OFS    = 11'd2;
   localparam logic [10:0] NEXT_LO_OFS    = 11'd3;
   localparam logic [10:0] ADDRESS_STEP_N = 11'd4;

   localparam logic [1:0] FORWARD_UP    = 2'd0;
   localparam logic [1:0] FORWARD_RIGHT = 2'd1;
   localparam logic [1:0] FORWARD_DOWN  = 2'd2;
   localparam logic [1:0] FORWARD_LEFT  = 2'd3;

   localparam logic [7:0] HEAD_POSITION_XY = 8'h44;

   function automatic logic [3:0] pos_x(input logic [7:0] pos);
      return pos[7:4];
   endfunction

   function automatic logic [3:0] pos_y(input logic [7:0] pos);
      return pos[3:0];
   endfunction

endpackage

// File: rtl/snake_bitmap_2buf.sv
// Work/committed 16x16 occupancy bitmaps with head register and a registered cell query.
// GREEDY_SNAKE_SELF_HIT_EN adds mark_hit (work bit already set at the marked cell).
import greedy_snake_pkg::*;

module snake_bitmap_2buf (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       mark,
   input  logic [7:0] mark_pos,
   input  logic       mark_first,
   input  logic       commit,
   input  logic       commit_valid,
   input  logic [3:0] qx,
   input  logic [3:0] qy,
   output logic       q_body,
   output logic       q_head
`ifdef GREEDY_SNAKE_SELF_HIT_EN
   ,
   output logic       mark_hit
`endif
);

   logic [255:0] work_bm;
   logic [255:0] cmt_bm;
   logic [7:0]   work_head;
   logic [7:0]   cmt_head;
   logic         head_valid;
   logic [7:0]   mark_idx;

   assign mark_idx = {pos_x(mark_pos), pos_y(mark_pos)};

`ifdef GREEDY_SNAKE_SELF_HIT_EN
   assign mark_hit = work_bm[mark_idx];
`endif

   // Queries read the committed copy before any same-edge commit lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_bm    <= '0;
         cmt_bm     <= '0;
         work_head  <= 8'h00;
         cmt_head   <= 8'h00;
         head_valid <= 1'b0;
         q_body     <= 1'b0;
         q_head     <= 1'b0;
      end else begin
         if (clear) begin
            work_bm   <= '0;
            work_head <= 8'h00;
         end else if (mark) begin
            work_bm[mark_idx] <= 1'b1;
            if (mark_first) work_head <= mark_pos;
         end
         if (commit) begin
            cmt_bm     <= work_bm;
            cmt_head   <= work_head;
            head_valid <= commit_valid;
         end
         q_body <= cmt_bm[{qx, qy}];
         q_head <= head_valid && ({qx, qy} == cmt_head);
      end
   end

endmodule

// File: rtl/greedy_snake_dpb_r.sv
// Walks the snake linked list over DPB port B, builds an occupancy bitmap and commits it atomically.
// Optional build macro: GREEDY_SNAKE_SELF_HIT_EN (adds self_hit body-on-body flag).
import greedy_snake_pkg::*;

module greedy_snake_dpb_r #(
   parameter int RD_LATENCY = 2,
   parameter int MAX_NODES  = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [10:0] list_length,
   input  logic [10:0] list_head_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        i_b_clk_en,
   output logic        i_b_data_en,
   output logic [10:0] i_b_address,
   input  logic [7:0]  o_b_data,
   input  logic [3:0]  qx,
   input  logic [3:0]  qy,
   output logic        q_body,
   output logic        q_head,
   output logic [10:0] node_cnt
`ifdef GREEDY_SNAKE_SELF_HIT_EN
   ,
   output logic        self_hit
`endif
);

   localparam logic [2:0]  K_POS  = 3'(RD_LATENCY);
   localparam logic [2:0]  K_NHI  = 3'(RD_LATENCY + 1);
   localparam logic [2:0]  K_LAST = 3'(RD_LATENCY + 2);
   localparam logic [10:0] MAX_N  = 11'(MAX_NODES);

   state_t      state, state_nxt;
   logic [2:0]  k;
   logic [10:0] node, len, cnt, cnt_inc, next_addr;
   logic [7:0]  pos;
   logic [2:0]  next_hi;
   logic        done_p;
   logic        accept, clear_c, mark_c, commit_c, end_c;

   assign i_b_clk_en  = 1'b1;
   assign i_b_data_en = 1'b1;
   assign accept      = (state == S_IDLE) && start && !busy;
   assign cnt_inc     = cnt + 11'd1;
   assign next_addr   = {next_hi, o_b_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:
            if (accept) state_nxt = (list_length == 11'd0) ? S_COMMIT : S_FETCH;
         S_FETCH:
            if (k == K_LAST) begin
               if (next_addr == NULL_ADDR)
                  state_nxt = (cnt_inc == len) ? S_COMMIT : S_FAIL;
               else if ((cnt_inc == len) || (cnt_inc == MAX_N))
                  state_nxt = S_FAIL;
            end
         S_COMMIT: state_nxt = S_IDLE;
         S_FAIL:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      clear_c  = accept;
      mark_c   = (state == S_FETCH) && (k == K_LAST);
      commit_c = (state == S_COMMIT);
      end_c    = (state == S_COMMIT) || (state == S_FAIL);
   end

   // done trails the commit by one cycle so a query issued alongside it already sees the new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k           <= 3'd0;
         node        <= 11'd0;
         len         <= 11'd0;
         cnt         <= 11'd0;
         pos         <= 8'h00;
         next_hi     <= 3'd0;
         i_b_address <= 11'd0;
         busy        <= 1'b0;
         done_p      <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         node_cnt    <= 11'd0;
      end else begin
         done_p <= end_c;
         done   <= done_p;
         if (done_p) busy <= 1'b0;
         if (accept) begin
            len         <= list_length;
            node        <= list_head_addr;
            i_b_address <= list_head_addr + POS_OFS;
            cnt         <= 11'd0;
            k           <= 3'd0;
            err         <= 1'b0;
            busy        <= 1'b1;
         end
         if (state == S_FETCH) begin
            k <= k + 3'd1;
            if (k == 3'd0)  i_b_address <= node + NEXT_HI_OFS;
            if (k == 3'd1)  i_b_address <= node + NEXT_LO_OFS;
            if (k == K_POS) pos <= o_b_data;
            if (k == K_NHI) next_hi <= o_b_data[2:0];
            if (k == K_LAST) begin
               k   <= 3'd0;
               cnt <= cnt_inc;
               if (state_nxt == S_FETCH) begin
                  node        <= next_addr;
                  i_b_address <= next_addr + POS_OFS;
               end
            end
         end
         if (commit_c)           node_cnt <= cnt;
         if (state == S_FAIL)    err      <= 1'b1;
      end
   end

`ifdef GREEDY_SNAKE_SELF_HIT_EN
   logic mark_hit, self_hit_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         self_hit_pend <= 1'b0;
         self_hit      <= 1'b0;
      end else begin
         if (clear_c)                self_hit_pend <= 1'b0;
         else if (mark_c && mark_hit) self_hit_pend <= 1'b1;
         if (commit_c) self_hit <= self_hit_pend;
      end
   end
`endif

   snake_bitmap_2buf u_bitmap (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear_c),
      .mark         (mark_c),
      .mark_pos     (pos),
      .mark_first   (cnt == 11'd0),
      .commit       (commit_c),
      .commit_valid (cnt != 11'd0),
      .qx           (qx),
      .qy           (qy),
      .q_body       (q_body),
      .q_head       (q_head)
`ifdef GREEDY_SNAKE_SELF_HIT_EN
      ,
      .mark_hit     (mark_hit)
`endif
   );

endmodule

// File: tb/tb_greedy_snake_dpb_r.sv
// Directed bench for greedy_snake_dpb_r with a 2-cycle DPB port-B read model.
// Covers GREEDY_SNAKE_SELF_HIT_EN when the macro is defined.
module tb_greedy_snake_dpb_r;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] list_length = 11'd0;
   logic [10:0] list_head_addr = 11'd0;
   logic        busy, done, err, i_b_clk_en, i_b_data_en;
   logic [10:0] i_b_address;
   logic [7:0]  o_b_data = 8'h00;
   logic [3:0]  qx = 4'd0;
   logic [3:0]  qy = 4'd0;
   logic        q_body, q_head;
   logic [10:0] node_cnt;
`ifdef GREEDY_SNAKE_SELF_HIT_EN
   logic        self_hit;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0]   mem [2048];
   logic [7:0]   rd_s1 = 8'h00;
   logic [255:0] body_good, head_good;

   greedy_snake_dpb_r #(.RD_LATENCY(2), .MAX_NODES(256)) dut (
      .clk(clk), .rst(rst), .start(start),
      .list_length(list_length), .list_head_addr(list_head_addr),
      .busy(busy), .done(done), .err(err),
      .i_b_clk_en(i_b_clk_en), .i_b_data_en(i_b_data_en),
      .i_b_address(i_b_address), .o_b_data(o_b_data),
      .qx(qx), .qy(qy), .q_body(q_body), .q_head(q_head),
      .node_cnt(node_cnt)
`ifdef GREEDY_SNAKE_SELF_HIT_EN
      , .self_hit(self_hit)
`endif
   );

   always #5 clk = ~clk;

   // DPB port B in output-register mode: two cycles from address to data.
   always @(posedge clk) begin
      if (i_b_clk_en) begin
         rd_s1    <= mem[i_b_address];
         o_b_data <= rd_s1;
      end
   end

   task automatic put_node(input logic [10:0] a, input logic [7:0] p, input logic [10:0] nxt);
      mem[a]      = p;
      mem[a + 1]  = 8'h00;
      mem[a + 2]  = {5'd0, nxt[10:8]};
      mem[a + 3]  = nxt[7:0];
   endtask

   task automatic run_scan(input logic [10:0] len, input logic [10:0] head, input int budget,
                           output int lat);
      @(negedge clk);
      list_length = len;
      list_head_addr = head;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic sweep(output logic [255:0] body, output logic [255:0] head);
      body = '0;
      head = '0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         {qx, qy} = 8'(i);
         @(posedge clk);
         #1;
         body[i] = q_body;
         head[i] = q_head;
      end
   endtask

   task automatic test_reset();
      logic [255:0] b, h;
      tests_run++;
      if ({busy, done, err, node_cnt} !== 14'd0) begin
         tests_failed++;
         $display("FAIL reset_status: got busy=%b done=%b err=%b node_cnt=%0d, want all 0", busy, done, err, node_cnt);
      end
      tests_run++;
      if ({i_b_clk_en, i_b_data_en, i_b_address} !== {2'b11, 11'd0}) begin
         tests_failed++;
         $display("FAIL reset_dpb: got en=%b%b addr=%0d, want en=11 addr=0", i_b_clk_en, i_b_data_en, i_b_address);
      end
      sweep(b, h);
      tests_run++;
      if ({b, h} !== 512'd0) begin
         tests_failed++;
         $display("FAIL reset_maps: got body=%h head=%h, want 0", b, h);
      end
   endtask

   task automatic test_empty();
      int lat;
      logic [255:0] b, h;
      run_scan(11'd0, 11'd4, 50, lat);
      tests_run++;
      if (lat !== 2 || err !== 1'b0 || node_cnt !== 11'd0) begin
         tests_failed++;
         $display("FAIL empty_scan: got lat=%0d err=%b cnt=%0d, want 2/0/0", lat, err, node_cnt);
      end
      sweep(b, h);
      tests_run++;
      if ({b, h} !== 512'd0) begin
         tests_failed++;
         $display("FAIL empty_maps: got body=%h head=%h, want 0", b, h);
      end
   endtask

   task automatic test_good_scan();
      int lat;
      logic [255:0] b, h;
      run_scan(11'd3, 11'd4, 100, lat);
      tests_run++;
      if (lat !== 17 || err !== 1'b0 || node_cnt !== 11'd3) begin
         tests_failed++;
         $display("FAIL good_scan: got lat=%0d err=%b cnt=%0d, want 17/0/3", lat, err, node_cnt);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL good_pulse: got done=%b busy=%b, want 0/0", done, busy);
      end
      sweep(b, h);
      tests_run++;
      if (b !== body_good) begin
         tests_failed++;
         $display("FAIL good_body: got %h want %h", b, body_good);
      end
      tests_run++;
      if (h !== head_good) begin
         tests_failed++;
         $display("FAIL good_head: got %h want %h", h, head_good);
      end
   endtask

   task automatic test_short_list();
      int lat;
      logic [255:0] b, h;
      run_scan(11'd4, 11'd4, 100, lat);
      tests_run++;
      if (lat !== 17 || err !== 1'b1 || node_cnt !== 11'd3) begin
         tests_failed++;
         $display("FAIL short_list: got lat=%0d err=%b cnt=%0d, want 17/1/3", lat, err, node_cnt);
      end
      sweep(b, h);
      tests_run++;
      if (b !== body_good || h !== head_good) begin
         tests_failed++;
         $display("FAIL short_keeps_frame: got body=%h head=%h", b, h);
      end
   endtask

   task automatic test_loop();
      int lat;
      put_node(11'd12, 8'h24, 11'd4);
      run_scan(11'd3, 11'd4, 100, lat);
      tests_run++;
      if (lat !== 17 || err !== 1'b1) begin
         tests_failed++;
         $display("FAIL loop_len3: got lat=%0d err=%b, want 17/1", lat, err);
      end
      run_scan(11'd300, 11'd4, 2000, lat);
      tests_run++;
      if (lat !== 1282 || err !== 1'b1 || node_cnt !== 11'd3) begin
         tests_failed++;
         $display("FAIL loop_max_nodes: got lat=%0d err=%b cnt=%0d, want 1282/1/3", lat, err, node_cnt);
      end
      put_node(11'd12, 8'h24, 11'd0);
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      int first = -1;
      @(negedge clk);
      list_length = 11'd3;
      list_head_addr = 11'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            start = 1'b1;
            list_length = 11'd0;
            list_head_addr = 11'd100;
         end
         if (c == 6) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) begin
            dones++;
            if (first < 0) first = c;
         end
      end
      tests_run++;
      if (dones !== 1 || first !== 17) begin
         tests_failed++;
         $display("FAIL busy_start_ignored: got dones=%0d first=%0d, want 1/17", dones, first);
      end
      tests_run++;
      if (err !== 1'b0 || node_cnt !== 11'd3) begin
         tests_failed++;
         $display("FAIL latched_inputs: got err=%b cnt=%0d, want 0/3", err, node_cnt);
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [255:0] b, h;
      @(negedge clk);
      list_length = 11'd3;
      list_head_addr = 11'd4;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || i_b_address !== 11'd0 || node_cnt !== 11'd0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_scan: got busy=%b addr=%0d cnt=%0d done=%b, want 0", busy, i_b_address, node_cnt, done);
      end
      @(negedge clk);
      rst = 1'b0;
      sweep(b, h);
      tests_run++;
      if ({b, h} !== 512'd0) begin
         tests_failed++;
         $display("FAIL reset_clears_frame: got body=%h head=%h, want 0", b, h);
      end
   endtask

`ifdef GREEDY_SNAKE_SELF_HIT_EN
   task automatic test_self_hit();
      int lat;
      put_node(11'd100, 8'h44, 11'd104);
      put_node(11'd104, 8'h34, 11'd108);
      put_node(11'd108, 8'h44, 11'd0);
      run_scan(11'd3, 11'd100, 100, lat);
      tests_run++;
      if (lat !== 17 || self_hit !== 1'b1) begin
         tests_failed++;
         $display("FAIL self_hit_set: got lat=%0d self_hit=%b, want 17/1", lat, self_hit);
      end
      run_scan(11'd3, 11'd4, 100, lat);
      tests_run++;
      if (lat !== 17 || self_hit !== 1'b0) begin
         tests_failed++;
         $display("FAIL self_hit_clear: got lat=%0d self_hit=%b, want 17/0", lat, self_hit);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      put_node(11'd4,  8'h44, 11'd8);
      put_node(11'd8,  8'h34, 11'd12);
      put_node(11'd12, 8'h24, 11'd0);
      body_good = '0;
      body_good[8'h44] = 1'b1;
      body_good[8'h34] = 1'b1;
      body_good[8'h24] = 1'b1;
      head_good = '0;
      head_good[8'h44] = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_empty();
      test_good_scan();
      test_short_list();
      test_loop();
      test_back_to_back();
      test_reset_mid_scan();
`ifdef GREEDY_SNAKE_SELF_HIT_EN
      test_self_hit();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/greedy_snake_dpb_r.md
Name: greedy_snake_dpb_r

Overview:
- Read-side companion to the snake list writer. It walks the snake linked list in the Gowin DPB through channel B, starting at list_head_addr and following next-pointers for list_length nodes.
- It builds a 16x16 occupancy bitmap and a head position, and commits them atomically to a display copy.
- The display/render stage queries cells (qx,qy) against the committed copy. The committed copy stays stable while the next scan runs.

Parameters:
- RD_LATENCY, 2, cycles from i_b_address registered to valid o_b_data (DPB output-register mode); legal range 1..4
- MAX_NODES, 256, hard walk limit (loop guard), independent of list_length
- NULL_ADDR, 11'd0, end-of-list pointer value

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request one scan; sampled only in IDLE
- list_length  in  11  node count from writer
- list_head_addr  in  11  head node byte address from writer
- busy  out  1  high from cycle after start accepted until done
- done  out  1  one-cycle pulse at end of scan (ok or error)
- err  out  1  sticky scan error; cleared on next accepted start
- i_b_clk_en  out  1  DPB B clock enable
- i_b_data_en  out  1  DPB B output enable
- i_b_address  out  11  DPB B byte address (registered)
- o_b_data  in  8  DPB B read data
- qx  in  4  query x
- qy  in  4  query y
- q_body  out  1  cell (qx,qy) occupied in committed bitmap; registered, 1-cycle latency
- q_head  out  1  cell (qx,qy) equals committed head; registered, 1-cycle latency
- node_cnt  out  11  nodes visited in last committed scan

Behaviour:
- Node layout, 4 bytes at node address A:
  - A+0: position byte, {x[3:0], y[3:0]}
  - A+1: reserved (0)
  - A+2: next[10:8] in bits [2:0]
  - A+3: next[7:0]
- Reset values:
  - busy=0, done=0, err=0, node_cnt=0, q_body=0, q_head=0
  - i_b_clk_en=1, i_b_data_en=1, i_b_address=0
  - Committed bitmap all 0; committed head=8'h00 with head_valid=0; state=IDLE.
- States: IDLE, FETCH, COMMIT, FAIL.
- IDLE:
  - On start: latch head and length, clear the work bitmap (256 bits, one cycle), clear err, set cnt=0, set busy.
  - If list_length==0, go to COMMIT; otherwise go to FETCH with node=head.
- FETCH, sub-counter k = 0..RD_LATENCY+2:
  - Address issue: k=0 drives addr=node, k=1 drives node+2, k=2 drives node+3.
  - k=RD_LATENCY: capture pos.
  - k=RD_LATENCY+1: capture next_hi.
  - k=RD_LATENCY+2: next = {next_hi[2:0], o_b_data}. Set work_bitmap[{pos[7:4],pos[3:0]}] and cnt++. If cnt==0 before the increment, record pos as work head.
  - Decide, using cnt after the increment:
    - next==NULL_ADDR and cnt==length: go to COMMIT.
    - next==NULL_ADDR and cnt<length: go to FAIL (short list).
    - next!=NULL_ADDR and (cnt==length or cnt==MAX_NODES): go to FAIL (long list / loop).
    - Otherwise node=next, k=0.
  - Each node costs exactly RD_LATENCY+3 cycles.
  - Addresses wrap mod 2048; no bounds check beyond the 11-bit width.
- COMMIT:
  - Copy the work bitmap and head to the committed copy, node_cnt=cnt, head_valid=(cnt!=0).
  - Pulse done, clear busy, go to IDLE.
- FAIL:
  - Set err=1, pulse done, clear busy, go to IDLE.
  - The committed copy is untouched, so the display keeps the previous good frame.
- Timing: done is asserted exactly N*(RD_LATENCY+3)+2 cycles after the start-sampling edge for a good list of N nodes; for N=0 it is 2 cycles.
- start while busy is ignored, not queued.
- list_length or list_head_addr changing mid-scan has no effect; they are latched at start.
- Query pipeline:
  - q_body <= committed_bitmap[{qx,qy}].
  - q_head <= head_valid && ({qx,qy}==committed_head).
  - When a commit and a query land in the same cycle, the query sees the old copy; the new copy is visible the next cycle.
- rst asserted mid-scan aborts immediately to the reset values, including the committed copy.

Optional Feature:
- Macro: GREEDY_SNAKE_SELF_HIT_EN.
- When defined:
  - Adds output self_hit (1 bit, reset 0).
  - During FETCH, if the work bitmap bit is already set when a node is marked, a self_hit_pend flag is set.
  - At COMMIT, self_hit <= self_hit_pend, so the game FSM sees body-on-body collision.
  - FAIL leaves self_hit unchanged.
- When undefined: the port, flag and compare logic are absent.

Decomposition:
- Shared package greedy_snake_pkg holds:
  - NULL_ADDR, node byte offsets (POS_OFS=0, NEXT_HI_OFS=2, NEXT_LO_OFS=3), ADDRESS_STEP_N=4
  - FORWARD_* encodings, HEAD_POSITION_XY=8'h44
  - Position helpers (x = pos[7:4], y = pos[3:0])
- One natural sub-module: snake_bitmap_2buf, the work and committed 256-bit bitmaps plus head register, with clear, mark, commit and registered query.

Test Plan:
- Writer reset layout (nodes at 4, 8, 12; pos 44, 34, 24; chain 4->8->12->0), length 3, start:
  - done at cycle 17 with err=0, node_cnt=3.
  - q_body=1 at (4,4), (3,4), (2,4) and 0 elsewhere; q_head=1 only at (4,4).
- Length 0, start:
  - done at cycle 2, bitmap all 0, q_head=0 everywhere, err=0.
- Same 3-node list but length 4 (short), after a good scan:
  - err=1, done pulse, node_cnt still 3, q_body unchanged from the prior frame.
- Node 12 next pointer set to 4 (loop), length 3:
  - FAIL after 3 nodes, err=1, exactly 15 FETCH cycles observed on i_b_address.
- start pulsed again while busy, and rst asserted at cycle 6 of a scan:
  - The second start is ignored and exactly one done is seen.
  - Reset clears busy, bitmap and node_cnt, and i_b_address=0 within the same cycle.
- GREEDY_SNAKE_SELF_HIT_EN defined, list with pos 44, 34, 44:
  - self_hit=1 at COMMIT.
  - A subsequent clean list clears self_hit to 0.
